shift_unit_pipe: RTL and testbench

- Parametrised, pipelined successor to the single-cycle 32-bit ALU shifter.
- Generalised to XLEN-wide data (RV64 default) and adds RV64 word variants (SLLW/SRLW/SRAW).
- Splits the log2(XLEN)-level barrel into STAGES registered stages under a valid/ready handshake with stall.
- Sits in the execute stage beside the ALU; results carry a tag back to writeback.

---
 rtl/shift_pkg.sv | 44 ++++
 rtl/shift_stage.sv | 36 +++
 rtl/shift_unit_pipe.sv | 135 +++++++++++++
 tb/tb_shift_unit_pipe.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Shared op encodings, stage payload and level-distribution helpers for the pipelined shifter.
// SHIFT_ROTATE_EN turns the two PASS encodings into ROR/ROL.
package shift_pkg;

    localparam logic [2:0] SHIFT_OP_SLL  = 3'b000;
    localparam logic [2:0] SHIFT_OP_SRL  = 3'b001;
    localparam logic [2:0] SHIFT_OP_SRA  = 3'b010;
    localparam logic [2:0] SHIFT_OP_SLLW = 3'b100;
    localparam logic [2:0] SHIFT_OP_SRLW = 3'b101;
    localparam logic [2:0] SHIFT_OP_SRAW = 3'b110;
`ifdef SHIFT_ROTATE_EN
    localparam logic [2:0] SHIFT_OP_ROR  = 3'b011;
    localparam logic [2:0] SHIFT_OP_ROL  = 3'b111;
`else
    localparam logic [2:0] SHIFT_OP_PASS  = 3'b011;
    localparam logic [2:0] SHIFT_OP_PASSW = 3'b111;
`endif

    // Payload is sized for the widest legal configuration; narrower builds truncate on use.
    localparam int MAX_XLEN  = 64;
    localparam int MAX_TAG_W = 16;

    typedef struct packed {
        logic [MAX_XLEN-1:0]  data;
        logic [5:0]           shamt;
        logic [2:0]           op;
        logic                 fill;
        logic                 word;
        logic [MAX_TAG_W-1:0] tag;
    } shift_payload_t;

    function automatic int levels_in_stage(int xlen, int stages, int s);
        int lv;
        lv = $clog2(xlen);
        return lv / stages + ((s < lv % stages) ? 1 : 0);
    endfunction

    function automatic int first_level(int xlen, int stages, int s);
        int lv;
        lv = $clog2(xlen);
        return s * (lv / stages) + ((s < lv % stages) ? s : lv % stages);
    endfunction

endpackage

// File: rtl/shift_stage.sv
// One combinational slice of the barrel: levels FIRST..FIRST+COUNT-1, each shifting by 2**level.
// With SHIFT_ROTATE_EN a rot input wraps the vacated bits instead of filling.
module shift_stage #(
    parameter int XLEN  = 64,
    parameter int FIRST = 0,
    parameter int COUNT = 1
) (
    input  logic [XLEN-1:0] data,
    input  logic [5:0]      shamt,
    input  logic            left,
`ifdef SHIFT_ROTATE_EN
    input  logic            rot,
`endif
    input  logic            fill,
    output logic [XLEN-1:0] result
);

    always_comb begin
        result = data;
        for (int k = 0; k < 6; k++) begin
            if (k >= FIRST && k < FIRST + COUNT && shamt[k]) begin
`ifdef SHIFT_ROTATE_EN
                if (rot)
                    result = left ? ((result << (1 << k)) | (result >> (XLEN - (1 << k))))
                                  : ((result >> (1 << k)) | (result << (XLEN - (1 << k))));
                else
`endif
                if (left)
                    result = result << (1 << k);
                else
                    result = (result >> (1 << k)) | ({XLEN{fill}} << (XLEN - (1 << k)));
            end
        end
    end

endmodule

// File: rtl/shift_unit_pipe.sv
// Pipelined XLEN-wide shifter with RV64 word ops, valid/ready handshake and whole-pipe stall.
// Optional SHIFT_ROTATE_EN adds ROR (op 011) and ROL (op 111).
module shift_unit_pipe
    import shift_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_data,
    input  logic [5:0]       in_shamt,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_data,
    output logic [TAG_W-1:0] out_tag
);

    localparam bit         IS64    = (XLEN == 64);
    localparam logic [5:0] SH_MASK = IS64 ? 6'h3f : 6'h1f;

    logic                         advance;
    logic                         accept;
    logic                         pass;
    logic [STAGES:1]              vld_pipe;
    shift_payload_t               s0;
    shift_payload_t               stg_in [STAGES];
    shift_payload_t               stg_d  [STAGES];
    shift_payload_t               stg_q  [STAGES];
    logic [STAGES-1:0]            left;
`ifdef SHIFT_ROTATE_EN
    logic [STAGES-1:0]            rot;
`endif
    logic [STAGES-1:0][XLEN-1:0]  res;

    assign out_valid = vld_pipe[STAGES];
    assign advance   = !out_valid || out_ready;
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    assign out_data  = XLEN'(stg_q[STAGES-1].data);
    assign out_tag   = TAG_W'(stg_q[STAGES-1].tag);

    // Fill bit and word handling are resolved here so later stages only see a plain barrel.
    always_comb begin
        s0       = '0;
        pass     = 1'b0;
        s0.data  = MAX_XLEN'(in_data);
        s0.shamt = in_shamt & SH_MASK;
        s0.op    = in_op;
        s0.tag   = MAX_TAG_W'(in_tag);
        unique case (in_op)
            SHIFT_OP_SLL, SHIFT_OP_SRL: ;
            SHIFT_OP_SRA:                 s0.fill = in_data[XLEN-1];
            SHIFT_OP_SLLW, SHIFT_OP_SRLW: s0.word = IS64;
            SHIFT_OP_SRAW: begin
                s0.word = IS64;
                s0.fill = IS64 ? in_data[31] : in_data[XLEN-1];
            end
`ifdef SHIFT_ROTATE_EN
            SHIFT_OP_ROR, SHIFT_OP_ROL: ;
`else
            SHIFT_OP_PASS, SHIFT_OP_PASSW: pass = 1'b1;
`endif
            default: ;
        endcase
        if (s0.word) begin
            s0.data     = {{32{s0.fill}}, in_data[31:0]};
            s0.shamt[5] = 1'b0;
        end
        if (pass)
            s0.shamt = '0;
    end

    always_comb begin
        stg_in[0] = s0;
        for (int s = 1; s < STAGES; s++)
            stg_in[s] = stg_q[s-1];
        for (int s = 0; s < STAGES; s++) begin
`ifdef SHIFT_ROTATE_EN
            left[s] = stg_in[s].op == SHIFT_OP_SLL || stg_in[s].op == SHIFT_OP_SLLW ||
                      stg_in[s].op == SHIFT_OP_ROL;
            rot[s]  = stg_in[s].op == SHIFT_OP_ROR || stg_in[s].op == SHIFT_OP_ROL;
`else
            left[s] = stg_in[s].op == SHIFT_OP_SLL || stg_in[s].op == SHIFT_OP_SLLW;
`endif
        end
    end

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        shift_stage #(
            .XLEN  (XLEN),
            .FIRST (first_level(XLEN, STAGES, s)),
            .COUNT (levels_in_stage(XLEN, STAGES, s))
        ) u_stage (
            .data   (XLEN'(stg_in[s].data)),
            .shamt  (stg_in[s].shamt),
            .left   (left[s]),
`ifdef SHIFT_ROTATE_EN
            .rot    (rot[s]),
`endif
            .fill   (stg_in[s].fill),
            .result (res[s])
        );
    end

    // Word results are sign-extended from bit 31 on the way into the last register.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stg_d[s]      = stg_in[s];
            stg_d[s].data = MAX_XLEN'(res[s]);
        end
        if (stg_in[STAGES-1].word)
            stg_d[STAGES-1].data = {{32{res[STAGES-1][31]}}, res[STAGES-1][31:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int s = 0; s < STAGES; s++)
                stg_q[s] <= '0;
        end else if (advance) begin
            vld_pipe[1] <= accept;
            for (int s = 2; s <= STAGES; s++)
                vld_pipe[s] <= vld_pipe[s-1];
            for (int s = 0; s < STAGES; s++)
                stg_q[s] <= stg_d[s];
        end
    end

endmodule

// File: tb/tb_shift_unit_pipe.sv
// Directed bench for shift_unit_pipe (XLEN=64, STAGES=2); rotate expectations follow SHIFT_ROTATE_EN.
module tb_shift_unit_pipe;

    localparam int XLEN   = 64;
    localparam int STAGES = 2;
    localparam int TAG_W  = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [XLEN-1:0]  in_data;
    logic [5:0]       in_shamt;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [XLEN-1:0]  out_data;
    logic [TAG_W-1:0] out_tag;

    int checks   = 0;
    int failures = 0;

    shift_unit_pipe #(.XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_op     (in_op),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_tag   (out_tag)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", name, obs, exp);
        end
    endtask

    // Called at a negedge: present one op, then verify latency, data and tag.
    task automatic run_op(input string name, input logic [2:0] op, input logic [63:0] d,
                          input logic [5:0] sh, input logic [4:0] tg, input logic [63:0] exp);
        in_valid = 1'b1;
        in_op    = op;
        in_data  = d;
        in_shamt = sh;
        in_tag   = tg;
        #1 check({name, "_in_ready"}, 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 1; i < STAGES; i++) begin
            check({name, "_early"}, 64'(out_valid), 64'd0);
            @(negedge clk);
        end
        check({name, "_valid"}, 64'(out_valid), 64'd1);
        check({name, "_data"}, out_data, exp);
        check({name, "_tag"}, 64'(out_tag), 64'(tg));
    endtask

    int               next_tag;
    int               exp_tag;
    int               stall_cnt;
    int               cyc;
    logic             acc;
    logic [XLEN-1:0]  held_data;
    logic [TAG_W-1:0] held_tag;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_op     = 3'b000;
        in_data   = '0;
        in_shamt  = '0;
        in_tag    = '0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", out_data, 64'd0);
        check("rst_out_tag", 64'(out_tag), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);

        run_op("sll63", 3'b000, 64'h0000_0000_0000_0001, 6'd63, 5'd7,  64'h8000_0000_0000_0000);
        run_op("sra4",  3'b010, 64'h8000_0000_0000_0000, 6'd4,  5'd3,  64'hF800_0000_0000_0000);
        run_op("srl4",  3'b001, 64'h8000_0000_0000_0000, 6'd4,  5'd12, 64'h0800_0000_0000_0000);
        run_op("sra0",  3'b010, 64'h8000_0000_0000_0000, 6'd0,  5'd13, 64'h8000_0000_0000_0000);
        run_op("srl63", 3'b001, 64'hFFFF_FFFF_FFFF_FFFF, 6'd63, 5'd14, 64'h0000_0000_0000_0001);
        run_op("sllw1", 3'b100, 64'hFFFF_FFFF_4000_0000, 6'd1,  5'd21, 64'hFFFF_FFFF_8000_0000);
        run_op("srlw0", 3'b101, 64'hFFFF_FFFF_4000_0000, 6'd0,  5'd22, 64'h0000_0000_4000_0000);
        run_op("sraw4", 3'b110, 64'h0000_0000_8000_0010, 6'd4,  5'd23, 64'hFFFF_FFFF_F800_0001);
        run_op("sllw33",3'b100, 64'h0000_0000_0000_0001, 6'd33, 5'd24, 64'h0000_0000_0000_0002);
`ifdef SHIFT_ROTATE_EN
        run_op("ror1",  3'b011, 64'h0000_0000_0000_0001, 6'd1,  5'd30, 64'h8000_0000_0000_0000);
        run_op("rol1",  3'b111, 64'h0000_0000_0000_0001, 6'd1,  5'd31, 64'h0000_0000_0000_0002);
`else
        run_op("pass3", 3'b011, 64'h0000_0000_0000_0001, 6'd1,  5'd30, 64'h0000_0000_0000_0001);
        run_op("pass7", 3'b111, 64'h0000_0000_0000_0001, 6'd1,  5'd31, 64'h0000_0000_0000_0001);
`endif
        @(negedge clk);

        // Stream tags 1..4; consumer stalls for 5 cycles from the first out_valid.
        next_tag  = 1;
        exp_tag   = 1;
        stall_cnt = 0;
        cyc       = 0;
        held_data = '0;
        held_tag  = '0;
        while (exp_tag <= 4 && cyc < 60) begin
            in_valid  = (next_tag <= 4);
            in_op     = 3'b000;
            in_data   = 64'(next_tag);
            in_shamt  = 6'd1;
            in_tag    = TAG_W'(next_tag);
            out_ready = (stall_cnt >= 5);
            #1;
            acc = in_valid && in_ready;
            if (out_valid && !out_ready) begin
                check("stall_in_ready", 64'(in_ready), 64'd0);
                if (stall_cnt > 0) begin
                    check("stall_data_stable", out_data, held_data);
                    check("stall_tag_stable", 64'(out_tag), 64'(held_tag));
                end
                held_data = out_data;
                held_tag  = out_tag;
                stall_cnt++;
            end else if (out_valid) begin
                check("order_tag", 64'(out_tag), 64'(exp_tag));
                check("order_data", out_data, 64'(exp_tag * 2));
                exp_tag++;
            end
            @(negedge clk);
            if (acc)
                next_tag++;
            cyc++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("stream_all_out", 64'(exp_tag), 64'd5);
        check("stream_stalled", 64'(stall_cnt), 64'd5);
        repeat (3) begin
            #1 check("stream_no_dup", 64'(out_valid), 64'd0);
            @(negedge clk);
        end

        // Reset with two ops in flight.
        in_valid = 1'b1;
        in_op    = 3'b000;
        in_data  = 64'h1;
        in_shamt = 6'd2;
        in_tag   = 5'd9;
        @(negedge clk);
        in_tag = 5'd10;
        @(negedge clk);
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (STAGES + 2) begin
            #1;
            check("rmf_out_valid", 64'(out_valid), 64'd0);
            check("rmf_in_ready", 64'(in_ready), 64'd1);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
